// File: rtl/sram_port_pkg.sv
// Shared types and lane helpers for the SRAM port-0 front end.
// Sub-word helpers are only referenced when SRAM_PORT_CTRL_SUBWORD_EN is defined.
package sram_port_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef struct packed {
      logic       we;
      logic       fault;
      logic [1:0] off;
      size_e      size;
      logic       uns;
   } meta_t;

   function automatic logic [3:0] wmask_gen(input size_e size, input logic [1:0] off);
      logic [3:0] m;
      unique case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_rep(input size_e size, input logic [31:0] wdata);
      logic [31:0] d;
      unique case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] dout, input logic [1:0] off,
                                                input size_e size, input logic uns);
      logic [31:0] sh;
      logic [31:0] r;
      sh = dout >> {off, 3'b000};
      unique case (size)
         SZ_BYTE: r = {{24{~uns & sh[7]}}, sh[7:0]};
         SZ_HALF: r = {{16{~uns & sh[15]}}, sh[15:0]};
         default: r = dout;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sram_port_rsp_fifo.sv
// Circular response FIFO with occupancy count; pointers wrap modulo DEPTH.
// Caller guarantees no push when full and no pop when empty.
module sram_port_rsp_fifo #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned WIDTH = 33,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop_i)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
      if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Port-0 request/response front end for the 256x32 OpenRAM data SRAM.
// Define SRAM_PORT_CTRL_SUBWORD_EN to enable byte/half accesses.
module sram_port_ctrl
   import sram_port_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_WMASKS = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned RSP_DEPTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

   size_e               size;
   logic                fault;
   logic                hs;
   logic                access;
   logic                inflight_q, inflight_d;
   meta_t               meta_q, meta_d;
   logic [CW-1:0]       count;
   logic [CW:0]         occupancy;
   logic [DATA_WIDTH:0] fifo_din, fifo_dout;
   logic [31:0]         rsp_word;
   logic                pop;

   assign size = size_e'(req_size);

   always_comb begin
      fault = (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
`ifdef SRAM_PORT_CTRL_SUBWORD_EN
      unique case (size)
         SZ_BYTE: ;
         SZ_HALF: fault = fault | req_addr[0];
         SZ_WORD: fault = fault | (req_addr[1:0] != 2'b00);
         SZ_ILL:  fault = 1'b1;
      endcase
`else
      if (size != SZ_WORD || req_addr[1:0] != 2'b00) fault = 1'b1;
`endif
   end

   // Credit counts in-flight plus buffered responses, so the buffer can never overflow.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign req_ready = rst_n && (occupancy < (CW+1)'(RSP_DEPTH));
   assign hs        = req_valid && req_ready;
   assign access    = hs && !fault;

   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      if (access) begin
         sram_csb0  = 1'b0;
         sram_web0  = !req_we;
         sram_addr0 = req_addr[ADDR_WIDTH+1:2];
`ifdef SRAM_PORT_CTRL_SUBWORD_EN
         sram_wmask0 = wmask_gen(size, req_addr[1:0]);
         sram_din0   = store_rep(size, req_wdata);
`else
         sram_wmask0 = '1;
         sram_din0   = req_wdata;
`endif
      end
   end

   always_comb begin
      inflight_d = hs;
      meta_d     = meta_q;
      if (hs) begin
         meta_d.we    = req_we;
         meta_d.fault = fault;
         meta_d.off   = req_addr[1:0];
         meta_d.size  = size;
         meta_d.uns   = req_unsigned;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         meta_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         meta_q     <= meta_d;
      end
   end

   always_comb begin
      rsp_word = '0;
      if (!meta_q.fault && !meta_q.we) begin
`ifdef SRAM_PORT_CTRL_SUBWORD_EN
         rsp_word = load_extract(sram_dout0, meta_q.off, meta_q.size, meta_q.uns);
`else
         rsp_word = sram_dout0;
`endif
      end
      fifo_din = {meta_q.fault, rsp_word};
   end

`ifndef SRAM_PORT_CTRL_SUBWORD_EN
   logic unused_meta;
   assign unused_meta = ^{meta_q.off, meta_q.size, meta_q.uns};
`endif

   assign rsp_valid = rst_n && (count != '0);
   assign rsp_rdata = rsp_valid ? fifo_dout[31:0] : '0;
   assign rsp_err   = rsp_valid && fifo_dout[DATA_WIDTH];
   assign pop       = rsp_valid && rsp_ready;

   sram_port_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_WIDTH + 1),
      .CW    (CW)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (inflight_q),
      .din_i   (fifo_din),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (count)
   );

endmodule
